// File: rtl/stl_uart_tl_bridge.sv
// UART packet <-> TileLink-UH bridge: one single-beat A request per command
// packet, one 128-bit response packet per D beat, illegal command or timeout.
//
// Ports:
//   clk, reset                      clock, sync active-high reset
//   packet_valid/ready/data         128-bit command packet in
//   tl_response_valid/ready/data    128-bit response packet out
//   tl_a_*                          TileLink A channel (master side)
//   tl_d_*                          TileLink D channel (master side)
//   debug_state                     current FSM state
//
// Optional: define STL_BRIDGE_TIMEOUT_EN to bound the D wait by TIMEOUT_CYCLES.
module stl_uart_tl_bridge #(
  parameter int unsigned SOURCE_ID      = 0,
  parameter int unsigned SOURCE_W       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                packet_valid,
  output logic                packet_ready,
  input  logic [127:0]        packet_data,
  output logic                tl_response_valid,
  input  logic                tl_response_ready,
  output logic [127:0]        tl_response_data,
  output logic                tl_a_valid,
  input  logic                tl_a_ready,
  output logic [2:0]          tl_a_opcode,
  output logic [2:0]          tl_a_param,
  output logic [3:0]          tl_a_size,
  output logic [SOURCE_W-1:0] tl_a_source,
  output logic [31:0]         tl_a_address,
  output logic [7:0]          tl_a_mask,
  output logic [63:0]         tl_a_data,
  input  logic                tl_d_valid,
  output logic                tl_d_ready,
  input  logic [2:0]          tl_d_opcode,
  input  logic [3:0]          tl_d_size,
  input  logic [SOURCE_W-1:0] tl_d_source,
  input  logic                tl_d_denied,
  input  logic                tl_d_corrupt,
  input  logic [63:0]         tl_d_data,
  output logic [1:0]          debug_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]          r_op;
  logic [7:0]          r_size;
  logic [7:0]          r_mask;
  logic [31:0]         r_addr;
  logic [63:0]         r_data;
  logic [SOURCE_W-1:0] r_src;
  logic [127:0]        r_resp;

  logic w_legal;
  logic w_pkt_fire;
  logic w_a_fire;
  logic w_d_fire;
  logic w_timeout;
  logic w_mismatch;
  logic [7:0]  w_d_flags;
  logic [63:0] w_d_data;
  logic w_unused;

  // Legality is judged on the incoming bytes so the illegal
  // response can be built in the same cycle the packet is taken.
  assign w_legal = ((packet_data[7:0] == 8'd0) ||
                    (packet_data[7:0] == 8'd4)) &&
                   (packet_data[15:8] <= 8'd3);

  assign w_pkt_fire = packet_valid && packet_ready;
  assign w_a_fire   = tl_a_valid && tl_a_ready;
  // Only a beat taken in WAIT_D counts; stale beats are swallowed.
  assign w_d_fire   = tl_d_valid && tl_d_ready && (r_state == S_WAIT);

  assign w_mismatch = tl_d_source != SOURCE_W'(SOURCE_ID);
  assign w_d_flags  = {5'd0, w_mismatch, tl_d_corrupt, tl_d_denied};
  // AccessAck carries no payload; never echo bus garbage.
  assign w_d_data   = (tl_d_opcode == 3'd1) ? tl_d_data : 64'd0;

`ifdef STL_BRIDGE_TIMEOUT_EN
  logic [31:0] r_tmo;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (w_a_fire) begin
      r_tmo <= '0;
    end else if (r_state == S_WAIT) begin
      r_tmo <= r_tmo + 32'd1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !tl_d_valid &&
                     (r_tmo == 32'(TIMEOUT_CYCLES - 1));
  assign w_unused  = ^packet_data[31:24];
`else
  assign w_timeout = 1'b0;
  assign w_unused  = ^{packet_data[31:24], 32'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next            = r_state;
    packet_ready      = 1'b0;
    tl_a_valid        = 1'b0;
    tl_d_ready        = 1'b0;
    tl_response_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        packet_ready = 1'b1;
`ifdef STL_BRIDGE_TIMEOUT_EN
        // Drain a D beat that arrives after its request timed out.
        tl_d_ready   = 1'b1;
`endif
        if (packet_valid) begin
          w_next = w_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: begin
        tl_a_valid = 1'b1;
        if (tl_a_ready) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        tl_d_ready = 1'b1;
        if (tl_d_valid || w_timeout) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        tl_response_valid = 1'b1;
        if (tl_response_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op   <= '0;
      r_size <= '0;
      r_mask <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_src  <= '0;
      r_resp <= '0;
    end else begin
      if (w_pkt_fire) begin
        r_op   <= packet_data[2:0];
        r_size <= packet_data[15:8];
        r_mask <= packet_data[23:16];
        r_addr <= packet_data[63:32];
        r_data <= packet_data[127:64];
        r_src  <= SOURCE_W'(SOURCE_ID);
        if (!w_legal) begin
          r_resp <= {64'd0, packet_data[63:32], 8'd0,
                     8'h08, packet_data[15:8], 8'd0};
        end
      end
      if (w_d_fire) begin
        r_resp <= {w_d_data, r_addr, 8'(tl_d_source),
                   w_d_flags, 8'(tl_d_size), 8'(tl_d_opcode)};
      end else if (w_timeout) begin
        r_resp <= {64'd0, r_addr, 8'd0, 8'h10, 8'd0, 8'd0};
      end
    end
  end

  assign tl_a_opcode      = r_op;
  assign tl_a_param       = 3'd0;
  assign tl_a_size        = r_size[3:0];
  assign tl_a_source      = r_src;
  assign tl_a_address     = r_addr;
  assign tl_a_mask        = r_mask;
  assign tl_a_data        = r_data;
  assign tl_response_data = r_resp;
  assign debug_state      = r_state;

endmodule

// File: tb/tb_stl_uart_tl_bridge.sv
// Self-checking bench for stl_uart_tl_bridge.
// Expected response packets are queued at stimulus time and popped on handshake.
module tb_stl_uart_tl_bridge;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         packet_valid = 1'b0;
  logic         packet_ready;
  logic [127:0] packet_data = '0;
  logic         tl_response_valid;
  logic         tl_response_ready = 1'b0;
  logic [127:0] tl_response_data;
  logic         tl_a_valid;
  logic         tl_a_ready = 1'b0;
  logic [2:0]   tl_a_opcode;
  logic [2:0]   tl_a_param;
  logic [3:0]   tl_a_size;
  logic [3:0]   tl_a_source;
  logic [31:0]  tl_a_address;
  logic [7:0]   tl_a_mask;
  logic [63:0]  tl_a_data;
  logic         tl_d_valid = 1'b0;
  logic         tl_d_ready;
  logic [2:0]   tl_d_opcode = '0;
  logic [3:0]   tl_d_size = '0;
  logic [3:0]   tl_d_source = '0;
  logic         tl_d_denied = 1'b0;
  logic         tl_d_corrupt = 1'b0;
  logic [63:0]  tl_d_data = '0;
  logic [1:0]   debug_state;

  int n_pass = 0;
  int n_tot  = 0;
  int a_cnt  = 0;
  logic [127:0] sb_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tl_a_valid) a_cnt <= a_cnt + 1;
  end

  stl_uart_tl_bridge #(
    .SOURCE_ID(0),
    .SOURCE_W(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .packet_valid(packet_valid),
    .packet_ready(packet_ready),
    .packet_data(packet_data),
    .tl_response_valid(tl_response_valid),
    .tl_response_ready(tl_response_ready),
    .tl_response_data(tl_response_data),
    .tl_a_valid(tl_a_valid),
    .tl_a_ready(tl_a_ready),
    .tl_a_opcode(tl_a_opcode),
    .tl_a_param(tl_a_param),
    .tl_a_size(tl_a_size),
    .tl_a_source(tl_a_source),
    .tl_a_address(tl_a_address),
    .tl_a_mask(tl_a_mask),
    .tl_a_data(tl_a_data),
    .tl_d_valid(tl_d_valid),
    .tl_d_ready(tl_d_ready),
    .tl_d_opcode(tl_d_opcode),
    .tl_d_size(tl_d_size),
    .tl_d_source(tl_d_source),
    .tl_d_denied(tl_d_denied),
    .tl_d_corrupt(tl_d_corrupt),
    .tl_d_data(tl_d_data),
    .debug_state(debug_state)
  );

  function automatic logic [127:0] mk_cmd(
    input logic [7:0] op, input logic [7:0] sz,
    input logic [7:0] mk, input logic [31:0] a,
    input logic [63:0] d);
    return {d, a, 8'h00, mk, sz, op};
  endfunction

  function automatic logic [127:0] mk_rsp(
    input logic [7:0] op, input logic [7:0] sz,
    input logic [7:0] fl, input logic [7:0] src,
    input logic [31:0] a, input logic [63:0] d);
    return {d, a, src, fl, sz, op};
  endfunction

  // Caller is at a negedge; returns at the negedge after acceptance.
  task automatic send_cmd(input logic [127:0] p);
    int n;
    n = 0;
    packet_valid = 1'b1;
    packet_data  = p;
    while (!packet_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_tot++;
      $display("FAIL send_cmd: packet_ready=%b want 1", packet_ready);
    end
    @(negedge clk);
    packet_valid = 1'b0;
  endtask

  task automatic fire_a();
    tl_a_ready = 1'b1;
    @(negedge clk);
    tl_a_ready = 1'b0;
  endtask

  task automatic d_beat(
    input logic [2:0] op, input logic [3:0] sz,
    input logic [3:0] src, input logic den,
    input logic cor, input logic [63:0] d);
    int n;
    n = 0;
    while (!tl_d_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_tot++;
      $display("FAIL d_beat: tl_d_ready=%b want 1", tl_d_ready);
    end
    tl_d_valid   = 1'b1;
    tl_d_opcode  = op;
    tl_d_size    = sz;
    tl_d_source  = src;
    tl_d_denied  = den;
    tl_d_corrupt = cor;
    tl_d_data    = d;
    @(negedge clk);
    tl_d_valid = 1'b0;
  endtask

  task automatic drain_resp(input string nm);
    int n;
    logic [127:0] e;
    n = 0;
    while (!tl_response_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_tot++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s: response with empty scoreboard", nm);
    end else begin
      e = sb_q.pop_front();
      if (tl_response_valid !== 1'b1 || tl_response_data !== e)
        $display("FAIL %s: got v=%b %h want 1 %h", nm,
                 tl_response_valid, tl_response_data, e);
      else
        n_pass++;
    end
    tl_response_ready = 1'b1;
    @(negedge clk);
    tl_response_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tot++;
    if ({packet_ready, tl_a_valid, tl_response_valid,
         debug_state} !== 5'b10000)
      $display("FAIL reset_ctl: got %b want 10000",
               {packet_ready, tl_a_valid, tl_response_valid,
                debug_state});
    else n_pass++;
    n_tot++;
    if ({tl_a_opcode, tl_a_param, tl_a_size, tl_a_source,
         tl_a_address, tl_a_mask, tl_a_data,
         tl_response_data} !== '0)
      $display("FAIL reset_data: A/resp fields not zero a=%h r=%h",
               tl_a_address, tl_response_data);
    else n_pass++;
`ifndef STL_BRIDGE_TIMEOUT_EN
    n_tot++;
    if (tl_d_ready !== 1'b0)
      $display("FAIL reset_d_ready: got %b want 0", tl_d_ready);
    else n_pass++;
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_get();
    send_cmd(mk_cmd(8'd4, 8'd3, 8'hFF, 32'h1000_0000, 64'd0));
    n_tot++;
    if ({tl_a_valid, tl_a_opcode, tl_a_param, tl_a_size,
         tl_a_source, tl_a_address, tl_a_mask} !==
        {1'b1, 3'd4, 3'd0, 4'd3, 4'd0, 32'h1000_0000, 8'hFF})
      $display("FAIL get_a: got v=%b op=%0d sz=%0d a=%h m=%h",
               tl_a_valid, tl_a_opcode, tl_a_size,
               tl_a_address, tl_a_mask);
    else n_pass++;
    sb_q.push_back(mk_rsp(8'd1, 8'd3, 8'h00, 8'd0,
                          32'h1000_0000, 64'hDEAD_BEEF_0123_4567));
    fire_a();
    n_tot++;
    if ({tl_a_valid, tl_d_ready, debug_state} !== 4'b0110)
      $display("FAIL get_wait: got %b want 0110",
               {tl_a_valid, tl_d_ready, debug_state});
    else n_pass++;
    d_beat(3'd1, 4'd3, 4'd0, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567);
    n_tot++;
    if ({tl_response_valid, tl_response_data[71:64],
         tl_response_data[127:120]} !== {1'b1, 8'h67, 8'hDE})
      $display("FAIL get_resp_lat: got v=%b b8=%h b15=%h",
               tl_response_valid, tl_response_data[71:64],
               tl_response_data[127:120]);
    else n_pass++;
    drain_resp("get_resp");
  endtask

  task automatic test_put_stall();
    logic [58:0] exp_a;
    exp_a = {1'b1, 3'd0, 3'd0, 4'd0, 8'h01, 32'h2000, 8'h55};
    send_cmd(mk_cmd(8'd0, 8'd0, 8'h01, 32'h2000, 64'h55));
    for (int i = 0; i < 5; i++) begin
      n_tot++;
      if ({tl_a_valid, tl_a_opcode, tl_a_param, tl_a_size,
           tl_a_mask, tl_a_address, tl_a_data[7:0]} !== exp_a ||
          tl_a_data[63:8] !== '0)
        $display("FAIL put_stable%0d: v=%b op=%0d a=%h d=%h",
                 i, tl_a_valid, tl_a_opcode, tl_a_address,
                 tl_a_data);
      else n_pass++;
      @(negedge clk);
    end
    fire_a();
    sb_q.push_back(mk_rsp(8'd0, 8'd0, 8'h00, 8'd0,
                          32'h2000, 64'd0));
    d_beat(3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 64'hFFFF_0000_AAAA_5555);
    drain_resp("put_resp");
  endtask

  task automatic test_illegal();
    int a0;
    a0 = a_cnt;
    send_cmd(mk_cmd(8'd2, 8'd2, 8'h0F, 32'h3000, 64'h77));
    n_tot++;
    if ({tl_a_valid, tl_response_valid} !== 2'b01)
      $display("FAIL illegal_op_lat: got %b want 01",
               {tl_a_valid, tl_response_valid});
    else n_pass++;
    sb_q.push_back(mk_rsp(8'd0, 8'd2, 8'h08, 8'd0,
                          32'h3000, 64'd0));
    drain_resp("illegal_op_resp");
    send_cmd(mk_cmd(8'd4, 8'd5, 8'hFF, 32'h3100, 64'd0));
    sb_q.push_back(mk_rsp(8'd0, 8'd5, 8'h08, 8'd0,
                          32'h3100, 64'd0));
    drain_resp("illegal_size_resp");
    n_tot++;
    if (a_cnt !== a0)
      $display("FAIL illegal_no_a: a_valid cycles got %0d want %0d",
               a_cnt, a0);
    else n_pass++;
  endtask

  task automatic test_d_flags();
    send_cmd(mk_cmd(8'd4, 8'd2, 8'h0F, 32'h44, 64'd0));
    fire_a();
    sb_q.push_back(mk_rsp(8'd1, 8'd2, 8'h04, 8'h03,
                          32'h44, 64'h0000_0000_CAFE_F00D));
    d_beat(3'd1, 4'd2, 4'd3, 1'b0, 1'b0, 64'h0000_0000_CAFE_F00D);
    drain_resp("src_mismatch");
    send_cmd(mk_cmd(8'd4, 8'd1, 8'h03, 32'h48, 64'd0));
    fire_a();
    sb_q.push_back(mk_rsp(8'd1, 8'd1, 8'h03, 8'h00,
                          32'h48, 64'h1234));
    d_beat(3'd1, 4'd1, 4'd0, 1'b1, 1'b1, 64'h1234);
    drain_resp("denied_corrupt");
  endtask

  task automatic test_back_to_back();
    logic [127:0] e;
    send_cmd(mk_cmd(8'd4, 8'd3, 8'hFF, 32'h100, 64'd0));
    fire_a();
    sb_q.push_back(mk_rsp(8'd1, 8'd3, 8'h00, 8'd0,
                          32'h100, 64'h1111));
    d_beat(3'd1, 4'd3, 4'd0, 1'b0, 1'b0, 64'h1111);
    packet_valid = 1'b1;
    packet_data  = mk_cmd(8'd0, 8'd2, 8'h0F, 32'h200, 64'h22);
    for (int i = 0; i < 10; i++) begin
      n_tot++;
      if ({packet_ready, tl_response_valid} !== 2'b01)
        $display("FAIL b2b_hold%0d: got %b want 01", i,
                 {packet_ready, tl_response_valid});
      else n_pass++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    n_tot++;
    if (tl_response_data !== e)
      $display("FAIL b2b_resp1: got %h want %h",
               tl_response_data, e);
    else n_pass++;
    tl_response_ready = 1'b1;
    @(negedge clk);
    tl_response_ready = 1'b0;
    n_tot++;
    if ({packet_ready, debug_state} !== 3'b100)
      $display("FAIL b2b_idle: got %b want 100",
               {packet_ready, debug_state});
    else n_pass++;
    @(negedge clk);
    packet_valid = 1'b0;
    n_tot++;
    if ({tl_a_valid, tl_a_address} !== {1'b1, 32'h200})
      $display("FAIL b2b_accept2: got v=%b a=%h want 1 200",
               tl_a_valid, tl_a_address);
    else n_pass++;
    fire_a();
    sb_q.push_back(mk_rsp(8'd0, 8'd2, 8'h00, 8'd0,
                          32'h200, 64'd0));
    d_beat(3'd0, 4'd2, 4'd0, 1'b0, 1'b0, 64'd0);
    drain_resp("b2b_resp2");
  endtask

  task automatic test_reset_mid();
    logic seen;
    send_cmd(mk_cmd(8'd4, 8'd3, 8'hFF, 32'h500, 64'd0));
    fire_a();
    tl_d_valid  = 1'b1;
    tl_d_opcode = 3'd1;
    tl_d_data   = 64'h9999;
    reset       = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    tl_d_valid = 1'b0;
    n_tot++;
    if ({debug_state, tl_response_valid, tl_a_address} !=
        {2'd0, 1'b0, 32'd0})
      $display("FAIL reset_mid: st=%0d rv=%b a=%h want 0 0 0",
               debug_state, tl_response_valid, tl_a_address);
    else n_pass++;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (tl_response_valid) seen = 1'b1;
    end
    n_tot++;
    if (seen !== 1'b0)
      $display("FAIL reset_mid_noresp: got %b want 0", seen);
    else n_pass++;
  endtask

`ifdef STL_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    logic seen;
    send_cmd(mk_cmd(8'd4, 8'd3, 8'hFF, 32'h600, 64'd0));
    fire_a();
    n = 0;
    while (debug_state == 2'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_tot++;
    if (n !== 16 || tl_response_valid !== 1'b1)
      $display("FAIL tmo_cycles: got %0d rv=%b want 16 1",
               n, tl_response_valid);
    else n_pass++;
    n_tot++;
    if ({tl_response_data[127:32], tl_response_data[23:16],
         tl_response_data[7:0]} !==
        {64'd0, 32'h600, 8'h10, 8'h00})
      $display("FAIL tmo_resp: got %h", tl_response_data);
    else n_pass++;
    tl_response_ready = 1'b1;
    @(negedge clk);
    tl_response_ready = 1'b0;
    n_tot++;
    if (tl_d_ready !== 1'b1)
      $display("FAIL tmo_idle_dready: got %b want 1", tl_d_ready);
    else n_pass++;
    d_beat(3'd1, 4'd3, 4'd0, 1'b0, 1'b0, 64'hBAD);
    seen = 1'b0;
    repeat (4) begin
      if (tl_response_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_tot++;
    if (seen !== 1'b0 || debug_state !== 2'd0)
      $display("FAIL tmo_stale: rv=%b st=%0d want 0 0",
               seen, debug_state);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_get();
    test_put_stall();
    test_illegal();
    test_d_flags();
    test_back_to_back();
    test_reset_mid();
`ifdef STL_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    n_tot++;
    if (sb_q.size() != 0)
      $display("FAIL sb_empty: %0d left want 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/stl_uart_tl_bridge.md
# stl_uart_tl_bridge

Converts 128-bit serial-TileLink command packets from the UART packet assembler into single-beat TileLink-UH A-channel requests, waits for the matching D-channel beat, and returns a 128-bit response packet to the UART response streamer. It sits between the UART packet client (upstream, both directions) and the chip's TileLink port (downstream). Exactly one transaction is outstanding at a time.

## Interface
- SOURCE_ID, 0: value driven on tl_a_source.
- SOURCE_W, 4: source field width.
- TIMEOUT_CYCLES, 1_000_000: D-wait limit (used only with the timeout feature).
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- packet_valid / packet_ready  in / out  1  command handshake.
- packet_data  in  128  command packet; byte 0 = bits [7:0].
- tl_response_valid / tl_response_ready  out / in  1  response handshake.
- tl_response_data  out  128  response packet.
- tl_a_valid / tl_a_ready  out / in  1  A handshake.
- tl_a_opcode  out  3; tl_a_param  out  3 (always 0); tl_a_size  out  4; tl_a_source  out  SOURCE_W.
- tl_a_address  out  32; tl_a_mask  out  8; tl_a_data  out  64.
- tl_d_valid / tl_d_ready  in / out  1  D handshake.
- tl_d_opcode  in  3; tl_d_size  in  4; tl_d_source  in  SOURCE_W; tl_d_denied  in  1; tl_d_corrupt  in  1; tl_d_data  in  64.
- debug_state  out  2  current FSM state.

## Operation
- Command packet: byte0 opcode (0 PutFullData, 4 Get), byte1 size (log2 bytes), byte2 mask, byte3 reserved, bytes4-7 address (little-endian), bytes8-15 data (little-endian).
- Legal command: opcode in {0,4} and size <= 3. Otherwise illegal: no TL traffic; response generated directly.
- States: IDLE(0) -> ISSUE(1) -> WAIT_D(2) -> RESP(3) -> IDLE.
- IDLE: packet_ready=1. On packet_valid, latch all fields; go ISSUE if legal, RESP if illegal.
- ISSUE: tl_a_valid=1, A fields stable from latched copy; on tl_a_ready go WAIT_D.
- WAIT_D: tl_d_ready=1; on tl_d_valid latch D fields, go RESP.
- RESP: tl_response_valid=1, data stable; on tl_response_ready go IDLE.
- Response packet: byte0 D opcode (0 AccessAck, 1 AccessAckData), byte1 D size, byte2 flags {bit0 denied, bit1 corrupt, bit2 source_mismatch, bit3 illegal_cmd, bit4 timeout}, byte3 D source zero-extended, bytes4-7 echoed request address, bytes8-15 D data (zero for AccessAck).
- Illegal-command response: byte0=0, byte1=latched size, flags=0x08, data=0.
- tl_d_source != SOURCE_ID: beat still accepted; flag bit2 set.

## Timing
- Reset values: packet_ready=1 (IDLE), tl_a_valid=0, tl_d_ready=0, tl_response_valid=0, tl_response_data=0, all A fields 0, debug_state=0.
- Packet accept to tl_a_valid: 1 cycle. D accept to tl_response_valid: 1 cycle. Illegal packet to tl_response_valid: 1 cycle.
- tl_a_ready and tl_a_valid same cycle: A fires, WAIT_D next cycle; D may arrive the following cycle.
- packet_ready low in ISSUE/WAIT_D/RESP; new packet accepted earliest 1 cycle after response handshake.
- Valids never drop before handshake; payload never changes while valid high.
- Reset mid-transaction: immediate return to IDLE; an in-flight D beat is not responded to.

## Configuration
- STL_BRIDGE_TIMEOUT_EN defined: 32-bit counter clears on WAIT_D entry, increments each WAIT_D cycle; reaching TIMEOUT_CYCLES goes RESP with flags=0x10, opcode 0, data 0. Stale D beat later: tl_d_ready=1 in IDLE, beat dropped silently.
- Undefined: no counter; WAIT_D waits indefinitely; tl_d_ready=0 outside WAIT_D.

## Test plan
- Get addr 0x1000_0000, size 3, mask 0xFF; D AccessAckData data 0xDEAD_BEEF_0123_4567 -> A opcode 4, response byte0=1, flags=0, bytes8-15 = 67 45 23 01 EF BE AD DE.
- PutFullData addr 0x2000, data 0x55, size 0, mask 0x01, tl_a_ready delayed 5 cycles -> A fields stable 5 cycles, response byte0=0, data 0.
- Opcode 2 -> no tl_a_valid ever, response flags=0x08 after 1 cycle.
- D source 3 vs SOURCE_ID 0 -> flags=0x04, byte3=0x03.
- tl_response_ready held low 10 cycles while second packet_valid high -> packet_ready stays 0, second packet accepted 1 cycle after response handshake.
- With STL_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=16, no D -> response flags=0x10 after 16 WAIT_D cycles; late D in IDLE drained, no extra response.
